data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 30 +++
 rtl/dsram_bank.sv | 33 +++
 rtl/data_sram_resp.sv | 126 ++++++++++++
 tb/tb_data_sram_resp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and types for the data SRAM responder: MMIO register map,
// default window bases and the read-return source encoding.
package data_sram_resp_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;
   localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h1C00_0000;

   localparam logic [15:0] OFF_TIMER_LO = 16'h0000;
   localparam logic [15:0] OFF_TIMER_HI = 16'h0004;
   localparam logic [15:0] OFF_SCRATCH  = 16'h0008;
   localparam logic [15:0] OFF_LED      = 16'h000C;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_MMIO = 2'd2
   } rsrc_e;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (we[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dsram_bank.sv
// Single-port 2^IDX_W x 32 synchronous RAM with per-byte write enables and a
// one-cycle registered read; a write cycle performs no read.
module dsram_bank import data_sram_resp_pkg::*; #(
   parameter int IDX_W = 12
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [3:0]       we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   localparam int DEPTH = 1 << IDX_W;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // NOTE: the array and its read register carry no reset so the tools can map
   // them onto a RAM macro; the top masks rdata_o until a real read returns.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i != 4'h0) begin
            mem_q[idx_i] <= lane_merge(mem_q[idx_i], wdata_i, we_i);
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: decodes RAM / MMIO / miss windows, hosts the timer,
// scratch, LED and error-count registers, and returns read data one cycle later.
module data_sram_resp import data_sram_resp_pkg::*; #(
   parameter int          IDX_W     = 12,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [7:0]  err_cnt
);

   logic [31:0] ram_off;
   logic        ram_hit, mmio_hit, is_wr;
   logic [15:0] mmio_off;
   logic [31:0] bank_rdata;

   logic [63:0] counter_q,    counter_d;
   logic [31:0] hi_shadow_q,  hi_shadow_d;
   logic [31:0] scratch_q,    scratch_d;
   logic [15:0] led_q,        led_d;
   logic [7:0]  err_cnt_q,    err_cnt_d;
   logic [31:0] mmio_rdata_q, mmio_rdata_d;
   rsrc_e       rsrc_q,       rsrc_d;

   // Offset subtraction keeps the RAM window test independent of base alignment.
   assign ram_off  = data_sram_addr - RAM_BASE;
   assign ram_hit  = (data_sram_addr >= RAM_BASE) && ((ram_off >> (IDX_W + 2)) == 32'd0);
   assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
   assign mmio_off = data_sram_addr[15:0];
   assign is_wr    = (data_sram_we != 4'h0);

   dsram_bank #(.IDX_W(IDX_W)) u_bank (
      .clk     (clk),
      .en_i    (data_sram_en && ram_hit),
      .we_i    (data_sram_we),
      .idx_i   (data_sram_addr[IDX_W+1:2]),
      .wdata_i (data_sram_wdata),
      .rdata_o (bank_rdata)
   );

   // NOTE: every next-state value gets its hold/default first, so no path
   // through the decode below can leave a variable unassigned and infer a latch.
   always_comb begin
      counter_d    = counter_q + 64'd1;
      hi_shadow_d  = hi_shadow_q;
      scratch_d    = scratch_q;
      led_d        = led_q;
      err_cnt_d    = err_cnt_q;
      mmio_rdata_d = mmio_rdata_q;
      rsrc_d       = rsrc_q;

      if (data_sram_en) begin
         if (ram_hit) begin
            if (!is_wr) rsrc_d = SRC_RAM;
         end else if (mmio_hit) begin
            if (is_wr) begin
               case (mmio_off)
                  OFF_SCRATCH: scratch_d = lane_merge(scratch_q, data_sram_wdata, data_sram_we);
                  OFF_LED: begin
                     led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
                     led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
                  end
                  default: ;
               endcase
            end else begin
               rsrc_d = SRC_MMIO;
               case (mmio_off)
                  OFF_TIMER_LO: begin
                     mmio_rdata_d = counter_q[31:0];
                     hi_shadow_d  = counter_q[63:32];
                  end
                  OFF_TIMER_HI: mmio_rdata_d = hi_shadow_q;
                  OFF_SCRATCH:  mmio_rdata_d = scratch_q;
                  OFF_LED:      mmio_rdata_d = {16'h0000, led_q};
                  default:      mmio_rdata_d = 32'h0000_0000;
               endcase
            end
         end else begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!is_wr) rsrc_d = SRC_ZERO;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q    <= '0;
         hi_shadow_q  <= '0;
         scratch_q    <= '0;
         led_q        <= '0;
         err_cnt_q    <= '0;
         mmio_rdata_q <= '0;
         rsrc_q       <= SRC_ZERO;
      end else begin
         counter_q    <= counter_d;
         hi_shadow_q  <= hi_shadow_d;
         scratch_q    <= scratch_d;
         led_q        <= led_d;
         err_cnt_q    <= err_cnt_d;
         mmio_rdata_q <= mmio_rdata_d;
         rsrc_q       <= rsrc_d;
      end
   end

   always_comb begin
      data_sram_rdata = 32'h0000_0000;
      case (rsrc_q)
         SRC_RAM:  data_sram_rdata = bank_rdata;
         SRC_MMIO: data_sram_rdata = mmio_rdata_q;
         default:  data_sram_rdata = 32'h0000_0000;
      endcase
   end

   assign led     = led_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed vector table, hand-written
// corner sequences, and random traffic against a transaction-level model.
module tb_data_sram_resp;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   data_sram_resp dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .err_cnt         (err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model state: word-addressed RAM contents, registers, and the
   // number of clock edges seen since reset release (the timer value).
   logic [31:0] ram_m [bit [31:0]];
   logic [31:0] m_rd, m_scratch, m_shadow;
   logic [15:0] m_led;
   logic [7:0]  m_err;
   logic [63:0] edges;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] we);
      logic [31:0] mask;
      mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic model_apply(input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] old_w, tmp;
      if (en) begin
         if (addr >= 32'h1C00_0000 && addr < 32'h1C00_4000) begin
            if (we != 4'h0) begin
               old_w = ram_m.exists(addr) ? ram_m[addr] : 32'h0;
               ram_m[addr] = merge(old_w, wd, we);
            end else begin
               m_rd = ram_m.exists(addr) ? ram_m[addr] : 32'h0;
            end
         end else if (addr[31:16] == 16'hBFAF) begin
            if (we != 4'h0) begin
               if (addr[15:0] == 16'h0008) m_scratch = merge(m_scratch, wd, we);
               if (addr[15:0] == 16'h000C) begin
                  tmp   = merge({16'h0, m_led}, wd, we);
                  m_led = tmp[15:0];
               end
            end else begin
               case (addr[15:0])
                  16'h0000: begin m_rd = edges[31:0]; m_shadow = edges[63:32]; end
                  16'h0004: m_rd = m_shadow;
                  16'h0008: m_rd = m_scratch;
                  16'h000C: m_rd = {16'h0, m_led};
                  default:  m_rd = 32'h0;
               endcase
            end
         end else begin
            if (m_err < 8'hFF) m_err = m_err + 8'd1;
            if (we == 4'h0) m_rd = 32'h0;
         end
      end
      edges = edges + 64'd1;
   endtask

   task automatic drive(input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
      data_sram_en    = en;
      data_sram_we    = we;
      data_sram_addr  = addr;
      data_sram_wdata = wd;
   endtask

   task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
      drive(en, we, addr, wd);
      model_apply(en, we, addr, wd);
      @(posedge clk); #1;
      check({tag, " rdata"}, {32'h0, data_sram_rdata}, {32'h0, m_rd});
      check({tag, " led"}, {48'h0, led}, {48'h0, m_led});
      check({tag, " err_cnt"}, {56'h0, err_cnt}, {56'h0, m_err});
   endtask

   task automatic model_reset();
      m_rd = '0; m_scratch = '0; m_shadow = '0; m_led = '0; m_err = '0; edges = '0;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [15:0] exp_led;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t vecs [21];

   logic [31:0] pool [9];
   logic [31:0] mmio_offs [6];
   logic [31:0] miss_addrs [3];

   initial begin
      vecs[0]  = '{1'b1, 4'hF, 32'h1C00_0010, 32'h1122_3344, 32'h0000_0000, 16'h0000, 8'd0};
      vecs[1]  = '{1'b1, 4'h2, 32'h1C00_0010, 32'hAAAA_AAAA, 32'h0000_0000, 16'h0000, 8'd0};
      vecs[2]  = '{1'b1, 4'h0, 32'h1C00_0010, 32'h0000_0000, 32'h1122_AA44, 16'h0000, 8'd0};
      vecs[3]  = '{1'b0, 4'h0, 32'h1C00_0010, 32'h0000_0000, 32'h1122_AA44, 16'h0000, 8'd0};
      vecs[4]  = '{1'b1, 4'h1, 32'hBFAF_000C, 32'h0000_00A5, 32'h1122_AA44, 16'h00A5, 8'd0};
      vecs[5]  = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0000_0000, 32'h0000_00A5, 16'h00A5, 8'd0};
      vecs[6]  = '{1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF, 32'h0000_00A5, 16'h00A5, 8'd0};
      vecs[7]  = '{1'b1, 4'h0, 32'hBFAF_0010, 32'h0000_0000, 32'h0000_0000, 16'h00A5, 8'd0};
      vecs[8]  = '{1'b1, 4'hC, 32'hBFAF_0008, 32'hDEAD_BEEF, 32'h0000_0000, 16'h00A5, 8'd0};
      vecs[9]  = '{1'b1, 4'h0, 32'hBFAF_0008, 32'h0000_0000, 32'hDEAD_0000, 16'h00A5, 8'd0};
      vecs[10] = '{1'b1, 4'h2, 32'hBFAF_000C, 32'h1234_5678, 32'hDEAD_0000, 16'h56A5, 8'd0};
      vecs[11] = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0000_0000, 32'h0000_56A5, 16'h56A5, 8'd0};
      vecs[12] = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 32'h0000_56A5, 16'h56A5, 8'd1};
      vecs[13] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 16'h56A5, 8'd2};
      vecs[14] = '{1'b1, 4'hF, 32'h1C00_3FFC, 32'h5A5A_0001, 32'h0000_0000, 16'h56A5, 8'd2};
      vecs[15] = '{1'b1, 4'h0, 32'h1C00_3FFC, 32'h0000_0000, 32'h5A5A_0001, 16'h56A5, 8'd2};
      vecs[16] = '{1'b1, 4'h0, 32'h1C00_4000, 32'h0000_0000, 32'h0000_0000, 16'h56A5, 8'd3};
      vecs[17] = '{1'b1, 4'h0, 32'h1BFF_FFFC, 32'h0000_0000, 32'h0000_0000, 16'h56A5, 8'd4};
      vecs[18] = '{1'b1, 4'h0, 32'h1C00_0010, 32'h0000_0000, 32'h1122_AA44, 16'h56A5, 8'd4};
      vecs[19] = '{1'b1, 4'hF, 32'h1C00_0000, 32'h0BAD_F00D, 32'h1122_AA44, 16'h56A5, 8'd4};
      vecs[20] = '{1'b1, 4'h0, 32'h1C00_0000, 32'h0000_0000, 32'h0BAD_F00D, 16'h56A5, 8'd4};

      for (int i = 0; i < 8; i++) pool[i] = 32'h1C00_0100 + 32'(4 * i);
      pool[8] = 32'h1C00_3FF8;
      mmio_offs  = '{32'hBFAF_0000, 32'hBFAF_0004, 32'hBFAF_0008,
                     32'hBFAF_000C, 32'hBFAF_0010, 32'hBFAF_0014};
      miss_addrs = '{32'h0000_0000, 32'h1C00_4000, 32'hBFB0_0000};

      // Reset state.
      reset = 1'b1;
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      #12;
      check("reset rdata", {32'h0, data_sram_rdata}, 64'h0);
      check("reset led", {48'h0, led}, 64'h0);
      check("reset err_cnt", {56'h0, err_cnt}, 64'h0);
      do_reset();

      // First edge after release samples a zero timer.
      step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, "first_timer");
      check("first_timer const", {32'h0, data_sram_rdata}, 64'h0);
      do_reset();

      // Directed vector table.
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         model_apply(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         @(posedge clk); #1;
         check($sformatf("vec%0d rdata", i), {32'h0, data_sram_rdata}, {32'h0, vecs[i].exp_rd});
         check($sformatf("vec%0d led", i), {48'h0, led}, {48'h0, vecs[i].exp_led});
         check($sformatf("vec%0d err_cnt", i), {56'h0, err_cnt}, {56'h0, vecs[i].exp_err});
      end

      // Back-to-back write/read to the same word, full and partial.
      step(1'b1, 4'hF, 32'h1C00_0020, 32'hCAFE_0001, "b2b_wr");
      step(1'b1, 4'h0, 32'h1C00_0020, 32'h0, "b2b_rd");
      check("b2b_rd const", {32'h0, data_sram_rdata}, 64'h0000_0000_CAFE_0001);
      step(1'b0, 4'h0, 32'h1C00_0020, 32'h0, "b2b_idle");
      check("b2b_idle const", {32'h0, data_sram_rdata}, 64'h0000_0000_CAFE_0001);
      step(1'b1, 4'h8, 32'h1C00_0020, 32'h7777_7777, "b2b_pwr");
      step(1'b1, 4'h0, 32'h1C00_0020, 32'h0, "b2b_prd");
      check("b2b_prd const", {32'h0, data_sram_rdata}, 64'h0000_0000_77FE_0001);

      // Random traffic against the model.
      for (int i = 0; i < 9; i++) step(1'b1, 4'hF, pool[i], $urandom, "rnd_init");
      for (int i = 0; i < 400; i++) begin
         logic        en;
         logic [3:0]  we;
         logic [31:0] addr;
         int          cls;
         en  = ($urandom_range(0, 9) != 0);
         we  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
         cls = $urandom_range(0, 9);
         if (cls < 5)      addr = pool[$urandom_range(0, 8)];
         else if (cls < 9) addr = mmio_offs[$urandom_range(0, 5)];
         else              addr = miss_addrs[$urandom_range(0, 2)];
         step(en, we, addr, $urandom, "rnd");
      end

      // 300 accesses to an unmapped address saturate the error counter.
      for (int i = 0; i < 300; i++)
         step(1'b1, (i % 3 == 0) ? 4'hF : 4'h0, 32'h0000_0000, $urandom, "miss300");
      check("miss300 err_cnt", {56'h0, err_cnt}, 64'hFF);
      step(1'b1, 4'h0, 32'h1C00_0010, 32'h0, "miss300_ram");
      check("miss300_ram const", {32'h0, data_sram_rdata}, 64'h0000_0000_1122_AA44);

      // Timer carry boundary: low word all ones, high word shadow must be 0.
      force dut.counter_q = 64'h0000_0000_FFFF_FFFF;
      drive(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      @(posedge clk); #1;
      check("timer_lo", {32'h0, data_sram_rdata}, 64'h0000_0000_FFFF_FFFF);
      release dut.counter_q;
      drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      @(posedge clk); #1;
      check("timer_hi", {32'h0, data_sram_rdata}, 64'h0);

      // Reset in the middle of a read.
      step(1'b1, 4'h0, 32'h1C00_0010, 32'h0, "pre_rst");
      #2 reset = 1'b1;
      #1;
      check("mid_rst rdata", {32'h0, data_sram_rdata}, 64'h0);
      check("mid_rst counter", dut.counter_q, 64'h0);
      check("mid_rst led", {48'h0, led}, 64'h0);
      check("mid_rst err_cnt", {56'h0, err_cnt}, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      check("in_rst rdata", {32'h0, data_sram_rdata}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, "post_rst_timer");
      step(1'b1, 4'h0, 32'h1C00_0010, 32'h0, "post_rst_ram");
      check("post_rst_ram const", {32'h0, data_sram_rdata}, 64'h0000_0000_1122_AA44);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
